// File: rtl/regfile_rd2w1.sv
// rtl/regfile_rd2w1.sv - two-read/one-write register file with write-first bypass and PI synchronisers
module regfile_rd2w1 #(
    parameter int DATA_W    = 16,
    parameter int NUM_GPR   = 28,
    parameter int NUM_PI    = 2,
    parameter int SPR_BASE  = 32,
    parameter int NUM_SPR   = 2,
    parameter int WREG_ADDR = 34,
    parameter int SEL_A_W   = 5,
    parameter int SEL_B_W   = 6
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_update_block,
    input  logic [SEL_A_W-1:0]       i_sel_a,
    input  logic [SEL_B_W-1:0]       i_sel_b,
    output logic [DATA_W-1:0]        o_data_a,
    output logic [DATA_W-1:0]        o_data_b,
    output logic                     o_read_valid,
    output logic                     o_err_a,
    output logic                     o_err_b,
    input  logic                     i_wr_en,
    input  logic [SEL_B_W-1:0]       i_wr_sel,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_wr_err,
    input  logic [NUM_PI*DATA_W-1:0] i_pi_in,
    output logic [DATA_W-1:0]        o_working_register
);

    // Port A must be able to address every GPR and PI register
    if (NUM_GPR + NUM_PI > 2 ** SEL_A_W) begin : g_bad_params
        $error("regfile_rd2w1: NUM_GPR + NUM_PI exceeds the port A address space");
    end

    logic [DATA_W-1:0] r_gpr    [NUM_GPR];
    logic [DATA_W-1:0] r_spr    [NUM_SPR];
    logic [DATA_W-1:0] r_pi_s1  [NUM_PI];
    logic [DATA_W-1:0] r_pi_s2  [NUM_PI];
    logic [DATA_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic              r_read_valid;
    logic              r_err_a;
    logic              r_err_b;
    logic              r_wr_err;

    logic [SEL_B_W-1:0] w_sel_a_ext;
    logic [31:0]        w_a32;
    logic [31:0]        w_b32;
    logic [31:0]        w_w32;
    logic               w_a_valid;
    logic               w_b_valid;
    logic               w_wr_ok;
    logic [DATA_W-1:0]  w_next_a;
    logic [DATA_W-1:0]  w_next_b;

    // Addresses are compared zero-extended; port A is first widened to the port B width
    assign w_sel_a_ext = SEL_B_W'(i_sel_a);
    assign w_a32       = 32'(w_sel_a_ext);
    assign w_b32       = 32'(i_sel_b);
    assign w_w32       = 32'(i_wr_sel);

    // Returns stored contents for any mapped address; unmapped addresses read as 0
    function automatic logic [DATA_W-1:0] f_read(input logic [31:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_GPR; k++) if (a == 32'(k)) v = r_gpr[k];
        for (int k = 0; k < NUM_PI; k++) if (a == 32'(NUM_GPR + k)) v = r_pi_s2[k];
        for (int k = 0; k < NUM_SPR; k++) if (a == 32'(SPR_BASE + k)) v = r_spr[k];
        if (a == 32'(WREG_ADDR)) v = r_wreg;
        return v;
    endfunction

    // Address validity per port and for the write target, plus the next captured data
    always_comb begin
        w_a_valid = (w_a32 < 32'(NUM_GPR + NUM_PI));
        w_b_valid = (w_b32 < 32'(NUM_GPR + NUM_PI)) ||
                    ((w_b32 >= 32'(SPR_BASE)) && (w_b32 < 32'(SPR_BASE + NUM_SPR))) ||
                    (w_b32 == 32'(WREG_ADDR));
        w_wr_ok   = i_wr_en && ((w_w32 < 32'(NUM_GPR)) ||
                    ((w_w32 >= 32'(SPR_BASE)) && (w_w32 < 32'(SPR_BASE + NUM_SPR))) ||
                    (w_w32 == 32'(WREG_ADDR)));
        w_next_a  = '0;
        w_next_b  = '0;
        if (w_a_valid) w_next_a = (w_wr_ok && (w_sel_a_ext == i_wr_sel)) ? i_wr_data : f_read(w_a32);
        if (w_b_valid) w_next_b = (w_wr_ok && (i_sel_b == i_wr_sel)) ? i_wr_data : f_read(w_b32);
    end

    // Two-flop synchroniser per PI lane
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_PI; k++) begin
                r_pi_s1[k] <= '0;
                r_pi_s2[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PI; k++) begin
                r_pi_s1[k] <= i_pi_in[k*DATA_W +: DATA_W];
                r_pi_s2[k] <= r_pi_s1[k];
            end
        end
    end

    // Write port: update the addressed register, or flag a rejected write for one cycle
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_GPR; k++) r_gpr[k] <= '0;
            for (int k = 0; k < NUM_SPR; k++) r_spr[k] <= '0;
            r_wreg   <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= i_wr_en && !w_wr_ok;
            if (w_wr_ok) begin
                for (int k = 0; k < NUM_GPR; k++) if (w_w32 == 32'(k)) r_gpr[k] <= i_wr_data;
                for (int k = 0; k < NUM_SPR; k++) if (w_w32 == 32'(SPR_BASE + k)) r_spr[k] <= i_wr_data;
                if (w_w32 == 32'(WREG_ADDR)) r_wreg <= i_wr_data;
            end
        end
    end

    // Read capture on Update_Block; data, error flags hold between captures
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data_a     <= '0;
            r_data_b     <= '0;
            r_err_a      <= 1'b0;
            r_err_b      <= 1'b0;
            r_read_valid <= 1'b0;
        end else begin
            r_read_valid <= i_update_block;
            if (i_update_block) begin
                r_data_a <= w_next_a;
                r_data_b <= w_next_b;
                r_err_a  <= !w_a_valid;
                r_err_b  <= !w_b_valid;
            end
        end
    end

    assign o_data_a           = r_data_a;
    assign o_data_b           = r_data_b;
    assign o_read_valid       = r_read_valid;
    assign o_err_a            = r_err_a;
    assign o_err_b            = r_err_b;
    assign o_wr_err           = r_wr_err;
    assign o_working_register = r_wreg;

endmodule
